// File: rtl/fp_cvt_wb_queue.sv
// Write-back queue between the int-to-double converter and the FP register-file write port.
// Optional statistics outputs (retired_cnt, max_occ) are enabled by defining FP_CVT_WB_STATS_EN.
module fp_cvt_wb_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_fflags,
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic [4:0]        wb_fflags,
  output logic [CNT_W-1:0]  count,
`ifdef FP_CVT_WB_STATS_EN
  output logic [31:0]       retired_cnt,
  output logic [CNT_W-1:0]  max_occ,
`endif
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] data_mem   [DEPTH];
  logic [4:0]        rd_mem     [DEPTH];
  logic [4:0]        fflags_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [DATA_W-1:0] store_data;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign in_ready = !full;
  assign wb_valid = !empty;
  assign count    = count_q;

  assign push = in_valid && !full;
  assign pop  = !empty && wb_ready;

  // Magnitude of zero is stored as +0 regardless of the sign bit.
  assign store_data = (in_data[DATA_W-2:0] == '0) ? '0 : in_data;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; empty masking below keeps stale contents invisible.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      data_mem[wr_ptr_q]   <= store_data;
      rd_mem[wr_ptr_q]     <= in_rd;
      fflags_mem[wr_ptr_q] <= in_fflags;
    end
  end

  always_comb begin
    wb_data   = '0;
    wb_rd     = '0;
    wb_fflags = '0;
    if (!empty) begin
      wb_data   = data_mem[rd_ptr_q];
      wb_rd     = rd_mem[rd_ptr_q];
      wb_fflags = fflags_mem[rd_ptr_q];
    end
  end

`ifdef FP_CVT_WB_STATS_EN
  logic [31:0]      retired_q, retired_d;
  logic [CNT_W-1:0] max_occ_q, max_occ_d;

  always_comb begin
    retired_d = retired_q;
    max_occ_d = max_occ_q;
    if (pop && !flush) retired_d = retired_q + 32'd1;
    if (count_d > max_occ_q) max_occ_d = count_d;
  end

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      max_occ_q <= '0;
    end else begin
      retired_q <= retired_d;
      max_occ_q <= max_occ_d;
    end
  end

  assign retired_cnt = retired_q;
  assign max_occ     = max_occ_q;
`endif

endmodule
